// File: rtl/instruction_memory.sv
// Word-addressed instruction store: combinational fetch by word index, byte-masked
// synchronous write port, sticky out-of-range status flags.
`timescale 1ns/1ps

module instruction_memory #(
    parameter int unsigned DEPTH     = 256,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] pc,
    output logic [31:0] instr,
    output logic        pc_oob,
    output logic        oob_seen,
    input  logic        we,
    input  logic [63:0] waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        wr_oob
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   im [0:DEPTH-1];

    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic          wr_addr_oob;
    logic          wr_attempt;
    logic          wr_en;

    logic          oob_seen_q, oob_seen_d;
    logic          wr_oob_q,   wr_oob_d;

    // Power-up contents only; this is the FPGA block-RAM init idiom, not a reset.
    initial begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            im[k] = '0;
        end
    end

    // Any set bit above the index field means out of range; there is no wrap-around.
    assign pc_oob      = |pc[63:AW];
    assign wr_addr_oob = |waddr[63:AW];
    assign rd_idx      = pc[AW-1:0];
    assign wr_idx      = waddr[AW-1:0];

    assign instr = pc_oob ? NOP : im[rd_idx];

    // A floating or unknown enable must never count as a write.
    assign wr_attempt = (we === 1'b1);
    assign wr_en      = wr_attempt && !wr_addr_oob;

    // NOTE: the array is deliberately left out of reset; reset only gates writes, the
    // negedge branch does nothing so stored program words survive rst_n.
    always @(posedge clk or negedge rst_n) begin
        if (rst_n) begin
            if (wr_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[b] === 1'b1) begin
                        im[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // NOTE: every always_comb output gets its value on every path, so no latch is inferred.
    always_comb begin
        oob_seen_d = oob_seen_q;
        wr_oob_d   = wr_oob_q;
        if (pc_oob) begin
            oob_seen_d = 1'b1;
        end
        if (wr_attempt && wr_addr_oob) begin
            wr_oob_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob_seen_q <= 1'b0;
            wr_oob_q   <= 1'b0;
        end else begin
            oob_seen_q <= oob_seen_d;
            wr_oob_q   <= wr_oob_d;
        end
    end

    assign oob_seen = oob_seen_q;
    assign wr_oob   = wr_oob_q;

endmodule

// File: tb/tb_instruction_memory.sv
// Scoreboard bench for instruction_memory: stimulus pushes model expectations, a
// monitor process pops and compares them against the DUT outputs.
`timescale 1ns/1ps

module tb_instruction_memory;

    localparam int unsigned DEPTH = 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        pc_oob;
        logic        oob_seen;
        logic        wr_oob;
    } exp_t;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst_n;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        pc_oob;
    logic        oob_seen;
    logic        we;
    logic [63:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wr_oob;

    instruction_memory #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc       (pc),
        .instr    (instr),
        .pc_oob   (pc_oob),
        .oob_seen (oob_seen),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wr_oob   (wr_oob)
    );

    always #10 if (clk_en) clk = ~clk;

    // Reference model: a plain word array plus the two sticky flags.
    logic [31:0] mem_m [DEPTH];
    logic        oob_m;
    logic        wr_m;

    exp_t q[$];
    event sample_ev;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] preload [10] = '{
        32'h00106433, 32'h0020e4b3, 32'h00308533, 32'h004105b3, 32'h00518633,
        32'h006206b3, 32'h00728733, 32'h008307b3, 32'h00938833, 32'h001008b3
    };

    function automatic logic [31:0] fetch_m(input logic [63:0] a);
        if (a < 64'(DEPTH)) return mem_m[int'(a)];
        return NOP;
    endfunction

    task automatic check(input string name);
        exp_t e;
        e.name     = name;
        e.instr    = fetch_m(pc);
        e.pc_oob   = (pc >= 64'(DEPTH));
        e.oob_seen = oob_m;
        e.wr_oob   = wr_m;
        q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    // One rising edge; the model applies the write and flag rules seen at that edge.
    task automatic do_cycle();
        logic [31:0] mask;
        @(posedge clk);
        if (rst_n) begin
            if (pc >= 64'(DEPTH)) oob_m = 1'b1;
            if (we) begin
                if (waddr < 64'(DEPTH)) begin
                    mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
                    mem_m[int'(waddr)] = (mem_m[int'(waddr)] & ~mask) | (wdata & mask);
                end else begin
                    wr_m = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #2;
        oob_m = 1'b0;
        wr_m  = 1'b0;
        check("async_reset");
        rst_n = 1'b1;
        #1;
    endtask

    // Monitor: every sample request drains the queue against the live outputs.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (instr !== e.instr || pc_oob !== e.pc_oob ||
                    oob_seen !== e.oob_seen || wr_oob !== e.wr_oob) begin
                    errors++;
                    $display("FAIL %s pc=%h: got instr=%h pc_oob=%b oob_seen=%b wr_oob=%b, want instr=%h pc_oob=%b oob_seen=%b wr_oob=%b",
                             e.name, pc, instr, pc_oob, oob_seen, wr_oob,
                             e.instr, e.pc_oob, e.oob_seen, e.wr_oob);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] p;
        rst_n = 1'b1;
        pc    = '0;
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        wstrb = '0;
        oob_m = 1'b0;
        wr_m  = 1'b0;
        for (int k = 0; k < DEPTH; k++) mem_m[k] = '0;
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 10; k++) begin
            dut.im[k] = preload[k];
            mem_m[k]  = preload[k];
        end

        // Clockless fetch of the preloaded program.
        for (int k = 0; k < 10; k++) begin
            pc = 64'(k);
            #19;
            check("preload_fetch");
        end
        pc = 64'(DEPTH);
        #5;
        check("pc_eq_depth");
        pc = 64'h8000_0000_0000_0000;
        #5;
        check("pc_top_bit");

        // Out-of-range fetch sets the sticky flag; reset clears it without a clock edge.
        rst_n  = 1'b1;
        clk_en = 1'b1;
        do_cycle();
        check("oob_seen_set");
        reset_pulse();

        // Full and partial byte writes, read back on the same address.
        pc    = 64'd5;
        we    = 1'b1;
        waddr = 64'd5;
        wdata = 32'hDEADBEEF;
        wstrb = 4'b1111;
        do_cycle();
        check("write_full");
        wdata = 32'h11223344;
        wstrb = 4'b0101;
        do_cycle();
        check("write_masked");
        wdata = 32'hCAFEF00D;
        wstrb = 4'b0000;
        do_cycle();
        check("write_strb0");

        // Dropped out-of-range write.
        waddr = 64'(DEPTH + 3);
        wstrb = 4'b1111;
        do_cycle();
        we = 1'b0;
        check("wr_oob_set");
        reset_pulse();
        check("im5_after_reset");

        // Writes while held in reset are ignored.
        rst_n = 1'b0;
        we    = 1'b1;
        waddr = 64'd2;
        wdata = 32'hFFFFFFFF;
        wstrb = 4'b1111;
        pc    = 64'd2;
        do_cycle();
        do_cycle();
        oob_m = 1'b0;
        wr_m  = 1'b0;
        check("write_in_reset");
        we    = 1'b0;
        rst_n = 1'b1;
        #1;

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                p = {$urandom, $urandom};
                if (p < 64'(DEPTH)) p = p + 64'(DEPTH);
                pc = p;
            end else begin
                pc = 64'($urandom_range(0, DEPTH - 1));
            end
            we = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                waddr = 64'(DEPTH) + 64'($urandom_range(0, 1000));
            end else begin
                waddr = 64'($urandom_range(0, DEPTH - 1));
            end
            wdata = $urandom;
            wstrb = 4'($urandom_range(0, 15));
            do_cycle();
            check("random");
            if ($urandom_range(0, 15) == 0) reset_pulse();
        end

        // Final sweep of every word with writes idle.
        we = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            pc = 64'(k);
            #1;
            check("sweep");
        end

        for (int t = 0; t < 50 && q.size() != 0; t++) #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
